// File: rtl/score_display_ctrl.sv
// Binary score to six-digit seven-segment display controller.
// Iterative double-dabble conversion, one shift per cycle, registered outputs.
module score_display_ctrl #(
    parameter int BIN_W = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [BIN_W-1:0] value,
    input  logic             blank_lz,
    output logic             busy,
    output logic             done,
    output logic [6:0]       hex0,
    output logic [6:0]       hex1,
    output logic [6:0]       hex2,
    output logic [6:0]       hex3,
    output logic [6:0]       hex4,
    output logic [6:0]       hex5
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t state, state_n;

    logic [BIN_W-1:0] bin, bin_n;
    logic [BIN_W-1:0] pend_val;
    logic             pend_v;
    logic             pend_blank;
    logic             blank;
    logic [23:0]      bcd, bcd_adj, bcd_n;
    logic [4:0]       cnt;
    logic             last;
    logic [6:0]       seg_n [6];
    logic             nz;
    logic [3:0]       dig;

    function automatic logic [BIN_W-1:0] clamp(input logic [BIN_W-1:0] v);
        if (32'(v) > 32'd999999)
            return BIN_W'(32'd999999);
        return v;
    endfunction

    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    assign last = (cnt == 5'(BIN_W - 1));

    // Add-3 correction on every nibble, then one left shift of {bcd, bin}
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 6; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
        bcd_n = {bcd_adj[22:0], bin[BIN_W-1]};
        bin_n = {bin[BIN_W-2:0], 1'b0};
    end

    // Scan from the top digit; blank until the first nonzero digit or hex0
    always_comb begin
        nz  = 1'b0;
        dig = 4'd0;
        for (int i = 5; i >= 0; i--) begin
            dig = bcd_n[4*i +: 4];
            if (dig != 4'd0 || i == 0)
                nz = 1'b1;
            seg_n[i] = (blank && !nz) ? 7'h7F : seg(dig);
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (load) state_n = CONV;
            CONV:    if (last) state_n = OUT;
            OUT:     state_n = pend_v ? CONV : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bin        <= '0;
            bcd        <= '0;
            cnt        <= '0;
            blank      <= 1'b0;
            pend_v     <= 1'b0;
            pend_val   <= '0;
            pend_blank <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            hex0       <= 7'h40;
            hex1       <= 7'h40;
            hex2       <= 7'h40;
            hex3       <= 7'h40;
            hex4       <= 7'h40;
            hex5       <= 7'h40;
        end else begin
            busy <= (state_n != IDLE);
            done <= (state == CONV) && last;
            case (state)
                IDLE: begin
                    if (load) begin
                        bin   <= clamp(value);
                        blank <= blank_lz;
                        bcd   <= '0;
                        cnt   <= '0;
                    end
                end
                CONV: begin
                    bin <= bin_n;
                    bcd <= bcd_n;
                    cnt <= cnt + 5'd1;
                    if (last) begin
                        hex0 <= seg_n[0];
                        hex1 <= seg_n[1];
                        hex2 <= seg_n[2];
                        hex3 <= seg_n[3];
                        hex4 <= seg_n[4];
                        hex5 <= seg_n[5];
                    end
                    if (load) begin
                        pend_v     <= 1'b1;
                        pend_val   <= clamp(value);
                        pend_blank <= blank_lz;
                    end
                end
                OUT: begin
                    if (pend_v) begin
                        bin   <= pend_val;
                        blank <= pend_blank;
                        bcd   <= '0;
                        cnt   <= '0;
                    end
                    // A load here refills the slot just drained
                    pend_v <= load;
                    if (load) begin
                        pend_val   <= clamp(value);
                        pend_blank <= blank_lz;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_score_display_ctrl.sv
// Directed self-checking bench for score_display_ctrl.
// Table vectors for single conversions plus multi-cycle sequences.
module tb_score_display_ctrl;

    localparam int BIN_W = 20;

    logic             clk;
    logic             reset;
    logic             load;
    logic [BIN_W-1:0] value;
    logic             blank_lz;
    logic             busy;
    logic             done;
    logic [6:0]       hex0, hex1, hex2, hex3, hex4, hex5;

    score_display_ctrl #(.BIN_W(BIN_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .value    (value),
        .blank_lz (blank_lz),
        .busy     (busy),
        .done     (done),
        .hex0     (hex0),
        .hex1     (hex1),
        .hex2     (hex2),
        .hex3     (hex3),
        .hex4     (hex4),
        .hex5     (hex5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          val;
        bit          blk;
        logic [41:0] exp;
    } vec_t;

    int checks;
    int errors;

    int ld_cyc [4];
    int ld_val [4];
    bit ld_blk [4];
    int nld;
    int rst_cyc;

    logic [41:0] hist [128];
    bit          bsy  [128];
    bit          dn   [128];
    int          dq [$];
    logic [41:0] hq [$];

    localparam logic [41:0] ALL0 =
        {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

    function automatic logic [41:0] hexs();
        return {hex5, hex4, hex3, hex2, hex1, hex0};
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run(input int n);
        dq.delete();
        hq.delete();
        hist[0] = hexs();
        bsy[0]  = busy;
        dn[0]   = done;
        for (int k = 0; k < n; k++) begin
            load  = 1'b0;
            reset = (k == rst_cyc);
            for (int j = 0; j < nld; j++) begin
                if (ld_cyc[j] == k) begin
                    load     = 1'b1;
                    value    = BIN_W'(ld_val[j]);
                    blank_lz = ld_blk[j];
                end
            end
            @(posedge clk);
            #1;
            load  = 1'b0;
            reset = 1'b0;
            hist[k+1] = hexs();
            bsy[k+1]  = busy;
            dn[k+1]   = done;
            if (done) begin
                dq.push_back(k + 1);
                hq.push_back(hexs());
            end
        end
    endtask

    function automatic int dqat(input int i);
        return (dq.size() > i) ? dq[i] : -1;
    endfunction

    function automatic logic [41:0] hqat(input int i);
        return (hq.size() > i) ? hq[i] : 42'h0;
    endfunction

    vec_t vt [6];
    int   gaps;
    int   ndone;

    initial begin
        checks   = 0;
        errors   = 0;
        load     = 1'b0;
        value    = '0;
        blank_lz = 1'b0;
        reset    = 1'b1;
        rst_cyc  = -1;
        nld      = 0;

        vt[0] = '{123456,  1'b0,
                  {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}};
        vt[1] = '{0,       1'b1,
                  {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}};
        vt[2] = '{907,     1'b1,
                  {7'h7F, 7'h7F, 7'h7F, 7'h10, 7'h40, 7'h78}};
        vt[3] = '{1048575, 1'b0,
                  {7'h10, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10}};
        vt[4] = '{100000,  1'b1,
                  {7'h79, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}};
        vt[5] = '{50,      1'b1,
                  {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h12, 7'h40}};

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset_hex", 64'(hexs()), 64'(ALL0));
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);

        // Single conversions
        for (int v = 0; v < 6; v++) begin
            nld       = 1;
            ld_cyc[0] = 0;
            ld_val[0] = vt[v].val;
            ld_blk[0] = vt[v].blk;
            run(24);
            chk($sformatf("vec%0d_ndone", v), 64'(dq.size()), 64'd1);
            chk($sformatf("vec%0d_lat", v), 64'(dqat(0)), 64'd21);
            chk($sformatf("vec%0d_hex", v), 64'(hqat(0)), 64'(vt[v].exp));
            chk($sformatf("vec%0d_busy1", v), 64'(bsy[1]), 64'd1);
            chk($sformatf("vec%0d_busy21", v), 64'(bsy[21]), 64'd1);
            chk($sformatf("vec%0d_busy22", v), 64'(bsy[22]), 64'd0);
            chk($sformatf("vec%0d_hold", v), 64'(hist[20]),
                64'(v == 0 ? ALL0 : vt[v-1].exp));
        end

        // Loads while busy: latest pending wins, 6 is dropped
        nld = 3;
        ld_cyc[0] = 0;  ld_val[0] = 5; ld_blk[0] = 1'b0;
        ld_cyc[1] = 3;  ld_val[1] = 6; ld_blk[1] = 1'b0;
        ld_cyc[2] = 10; ld_val[2] = 7; ld_blk[2] = 1'b0;
        run(60);
        chk("pend_ndone", 64'(dq.size()), 64'd2);
        chk("pend_t1", 64'(dqat(0)), 64'd21);
        chk("pend_t2", 64'(dqat(1)), 64'd42);
        chk("pend_hex1", 64'(hqat(0)),
            64'({7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h12}));
        chk("pend_hex2", 64'(hqat(1)),
            64'({7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h78}));
        gaps = 0;
        for (int k = 1; k <= 42; k++)
            if (!bsy[k]) gaps++;
        chk("pend_busy_gaps", 64'(gaps), 64'd0);
        chk("pend_busy_end", 64'(bsy[43]), 64'd0);

        // Reset in the middle of converting 42
        nld = 1;
        ld_cyc[0] = 0; ld_val[0] = 42; ld_blk[0] = 1'b0;
        rst_cyc = 8;
        run(40);
        rst_cyc = -1;
        chk("rst_hold", 64'(hist[8]),
            64'({7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h78}));
        chk("rst_hex", 64'(hist[9]), 64'(ALL0));
        chk("rst_busy", 64'(bsy[9]), 64'd0);
        chk("rst_busy_pre", 64'(bsy[8]), 64'd1);
        ndone = 0;
        for (int k = 1; k <= 40; k++)
            if (dn[k]) ndone++;
        chk("rst_no_done", 64'(ndone), 64'd0);
        chk("rst_idle", 64'(bsy[40]), 64'd0);

        run(24);
        chk("rst_redo_lat", 64'(dqat(0)), 64'd21);
        chk("rst_redo_hex", 64'(hqat(0)),
            64'({7'h40, 7'h40, 7'h40, 7'h40, 7'h19, 7'h24}));

        // Load coinciding with the OUT cycle that drains pending 10
        nld = 3;
        ld_cyc[0] = 0;  ld_val[0] = 123; ld_blk[0] = 1'b1;
        ld_cyc[1] = 5;  ld_val[1] = 10;  ld_blk[1] = 1'b1;
        ld_cyc[2] = 21; ld_val[2] = 99;  ld_blk[2] = 1'b1;
        run(70);
        chk("drain_ndone", 64'(dq.size()), 64'd3);
        chk("drain_t1", 64'(dqat(0)), 64'd21);
        chk("drain_t2", 64'(dqat(1)), 64'd42);
        chk("drain_t3", 64'(dqat(2)), 64'd63);
        chk("drain_hex1", 64'(hqat(0)),
            64'({7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30}));
        chk("drain_hex2", 64'(hqat(1)),
            64'({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h40}));
        chk("drain_hex3", 64'(hqat(2)),
            64'({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h10, 7'h10}));
        chk("drain_busy_end", 64'(bsy[64]), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/score_display_ctrl.md
Name: score_display_ctrl

Overview:
- Sequential controller that drives the six seven-segment digits of the board display from a binary score.
- Accepts a binary value through a load handshake, converts it to BCD with an iterative shift-add-3 (double-dabble) engine, one shift per cycle.
- Encodes each digit to active-low segments, with optional leading-zero blanking.
- Sits between the game-state logic (score/round counters) and the HEX0..HEX5 pins. Outputs are registered and change only on a completed conversion.

Parameters:
- BIN_W, 20, width of the binary input. Legal range 4..20. Sets the conversion length in cycles.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- load  in  1  one-cycle request to display value
- value  in  BIN_W  unsigned binary score; sampled when load=1
- blank_lz  in  1  1 = blank leading zeros; sampled with value
- busy  out  1  conversion in progress
- done  out  1  one-cycle pulse when HEX outputs update
- hex0  out  7  least-significant digit, segments {g,f,e,d,c,b,a}, active low
- hex1, hex2, hex3, hex4  out  7 each  digits 1..4, same encoding
- hex5  out  7  most-significant digit, same encoding

Behaviour:
- Reset, synchronous, active-high, wins over everything:
  - state=IDLE, busy=0, done=0, pending slot cleared.
  - hex0..hex5 = 7'h40 (display "000000").
  - A conversion in flight is abandoned; no done pulse.
- Segment encoding, one bit per segment, 0 = lit:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex values).
  - blank=7F.
  - Only BCD 0..9 can reach the encoder.
- Capture:
  - On a cycle with load=1, the controller takes value and blank_lz.
  - If value > 999999, it is clamped to 999999 (relevant only when BIN_W=20).
- States:
  - IDLE: busy=0. If load=1, capture and go to CONV. busy=1 from the next cycle.
  - CONV: runs exactly BIN_W cycles. Each cycle:
    - Every 4-bit BCD nibble >=5 gets +3 (all six nibbles evaluated in parallel).
    - Then {bcd[23:0], bin} is shifted left by 1.
    - Shift counter counts 0..BIN_W-1; after the last shift, go to OUT.
  - OUT: one cycle.
    - hex registers load the encoded digits; done=1 for this cycle only.
    - If blank_lz was 1 at capture: digits above the highest nonzero digit show 7F. hex0 is never blanked, so value 0 shows "     0".
    - Next state: CONV if the pending slot is full (that value is moved in and the slot cleared, busy stays 1); otherwise IDLE.
- Latency: load in cycle t (IDLE) → done and new hex values in cycle t+BIN_W+1. busy is high in cycles t+1..t+BIN_W+1.
- Load while busy (CONV or OUT):
  - value and blank_lz go into a one-deep pending slot; a newer load overwrites an older pending one (latest wins).
  - The in-flight conversion is never disturbed.
- Load in the same cycle OUT drains the pending slot:
  - The new load goes into the pending slot.
  - The drained value starts converting.
- Back-to-back loads in IDLE followed by CONV: the second is pended.
- hex outputs hold their value between updates; no intermediate BCD is ever visible.
- done and busy are registered outputs; no combinational path from load to any output.

Test Plan:
- Reset then idle → hex0..5=40, busy=0, done=0. load value=123456, blank_lz=0 at cycle t → done at t+21; hex5..hex0 = 79,24,30,19,12,02; busy low at t+22.
- load value=0, blank_lz=1 → hex0=40, hex1..hex5=7F. Then value=907, blank_lz=1 → hex2=10, hex1=40, hex0=78, hex3..5=7F.
- load value=1048575, blank_lz=0 → clamp; all digits=10 ("999999").
- load 5 at t, then load 6 at t+3 and load 7 at t+10 (both while busy) → exactly two done pulses: first shows 5, second shows 7 (6 is dropped). The second conversion starts directly from OUT, and busy never drops between them.
- Assert reset at t+8 mid-conversion of 42 → hex stays at its pre-reset value until the reset cycle, then 40 everywhere. No done pulse, busy=0. A fresh load of 42 then completes normally.
- load 99 coinciding with the OUT cycle of a pended value 10 → done shows 10, then done shows 99, each exactly BIN_W+1 cycles apart.
